// File: rtl/xulie_detect_ctrl.sv
// rtl/xulie_detect_ctrl.sv - word sequencer feeding a programmable-pattern Moore detector
//
// Accepts parallel words on a valid/ready handshake, shifts them MSB-first one
// bit per clock into an overlapping Moore pattern detector, counts matches per
// word and pulses Done once the word is finished.
//
// Ports:
//   Clk         rising-edge clock
//   Reset       asynchronous active-low reset
//   Pat_ld      load Pat_in as pattern (IDLE only), clears history
//   Pat_in      pattern, bit PAT_W-1 is the oldest bit
//   Clear_hist  clear detector history (IDLE only)
//   In_valid    In_data valid
//   In_data     word to scan
//   In_ready    high in IDLE; word accepted when In_valid && In_ready
//   Dout        registered match flag for the most recently shifted bit
//   Match_cnt   matches in the current / most recent word (saturating)
//   Busy        high while shifting
//   Done        one-cycle pulse, Match_cnt final

module xulie_detect_ctrl #(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Pat_ld,
   input  logic [PAT_W-1:0]  Pat_in,
   input  logic              Clear_hist,
   input  logic              In_valid,
   input  logic [WORD_W-1:0] In_data,
   output logic              In_ready,
   output logic              Dout,
   output logic [CNT_W-1:0]  Match_cnt,
   output logic              Busy,
   output logic              Done
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int HL_W  = $clog2(PAT_W + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
   localparam logic [HL_W-1:0]  HL_FULL  = HL_W'(PAT_W);
   localparam logic [PAT_W-1:0] RST_PAT  = PAT_W'(4'b0110);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [PAT_W-1:0]  pattern;
   logic [WORD_W-1:0] sword;
   logic [IDX_W-1:0]  idx;
   logic [PAT_W-1:0]  hist;
   logic [HL_W-1:0]   hlen;

   logic              bit_in;
   logic [PAT_W-1:0]  hist_nx;
   logic [HL_W-1:0]   hlen_nx;
   logic              hit;
   logic              last_bit;

   // The shift word is consumed from its MSB, so the current bit is always
   // the top bit of the register.
   assign bit_in   = sword[WORD_W-1];
   assign hist_nx  = {hist[PAT_W-2:0], bit_in};
   assign hlen_nx  = (hlen == HL_FULL) ? hlen : hlen + HL_W'(1);
   // A match needs a full window; after a history clear, leading zero fill
   // must not match an all-zero-prefix pattern.
   assign hit      = (hist_nx == pattern) && (hlen_nx == HL_FULL);
   assign last_bit = (idx == LAST_IDX);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Handshake and status outputs are decoded from state only.
   always_comb begin
      state_nx = state;
      In_ready = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      case (state)
         S_IDLE: begin
            In_ready = 1'b1;
            if (In_valid) begin
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            Busy = 1'b1;
            if (last_bit) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            Done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pattern   <= RST_PAT;
         sword     <= '0;
         idx       <= '0;
         hist      <= '0;
         hlen      <= '0;
         Dout      <= 1'b0;
         Match_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // Pattern load wins over a plain history clear; both take
               // effect before the first bit of a word accepted on this edge.
               if (Pat_ld) begin
                  pattern <= Pat_in;
                  hist    <= '0;
                  hlen    <= '0;
               end else if (Clear_hist) begin
                  hist <= '0;
                  hlen <= '0;
               end
               if (In_valid) begin
                  sword     <= In_data;
                  idx       <= '0;
                  Match_cnt <= '0;
                  Dout      <= 1'b0;
               end
            end
            S_SHIFT: begin
               sword <= sword << 1;
               hist  <= hist_nx;
               hlen  <= hlen_nx;
               idx   <= idx + IDX_W'(1);
               Dout  <= hit;
               if (hit && (Match_cnt != '1)) begin
                  Match_cnt <= Match_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               Dout <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
